// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2,
        StErr   = 2'd3
    } fetch_state_e;

    localparam int unsigned FETCH_ADDR_WIDTH = 12;
    localparam logic [FETCH_ADDR_WIDTH-1:0] BOOT_END  = 12'h100;
    localparam logic [FETCH_ADDR_WIDTH-1:0] RESET_VEC = 12'h080;
    localparam int unsigned TIMEOUT = 255;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Flash wait counter: counts stalled FETCH cycles and flags expiry on the last one.
module fetch_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            cnt_q <= 8'd0;
        end else if (clear) begin
            cnt_q <= 8'd0;
        end else if (inc) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Fires on the LIMIT-th consecutive stalled cycle.
    assign expired = inc && !clear && (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: issues flash reads at the PC, holds the byte for the decoder,
// and drives PC increment/load pulses for consumes and branches.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BOOT_LIMIT = 32'h100,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_next,
    output logic                  pc_gate,
    output logic                  flash_req,
    output logic [ADDR_WIDTH-1:0] flash_addr,
    input  logic                  flash_ack,
    input  logic [DATA_WIDTH-1:0] flash_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  instr_boot,
    input  logic                  branch_req,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic                  branch_ack,
    output logic                  fetch_error
);

    fetch_state_e          state_q;
    logic                  pend_valid_q;
    logic [ADDR_WIDTH-1:0] pend_addr_q;
    logic [DATA_WIDTH-1:0] instr_data_q;
    logic [ADDR_WIDTH-1:0] instr_addr_q;
    logic                  instr_boot_q;
    logic                  tmo_clear;
    logic                  tmo_inc;
    logic                  tmo_expired;

    // Counter restarts on every FETCH entry, including re-entry after a discarded ack.
    assign tmo_clear = (state_q != StFetch) || flash_ack;
    assign tmo_inc   = (state_q == StFetch) && !flash_ack;

    fetch_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .arst_n (arst_n),
        .clear  (tmo_clear),
        .inc    (tmo_inc),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            instr_data_q <= '0;
            instr_addr_q <= '0;
            instr_boot_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!branch_req && en) state_q <= StFetch;
                end
                StFetch: begin
                    if (flash_ack) begin
                        if (pend_valid_q) begin
                            pend_valid_q <= 1'b0;
                            state_q      <= en ? StFetch : StIdle;
                        end else begin
                            instr_data_q <= flash_rdata;
                            instr_addr_q <= pc_in;
                            instr_boot_q <= (pc_in < ADDR_WIDTH'(BOOT_LIMIT));
                            state_q      <= StHold;
                        end
                    end else begin
                        if (branch_req && !pend_valid_q) begin
                            pend_valid_q <= 1'b1;
                            pend_addr_q  <= branch_addr;
                        end
                        if (tmo_expired) state_q <= StErr;
                    end
                end
                StHold: begin
                    if (branch_req || instr_ready) state_q <= en ? StFetch : StIdle;
                end
                default: ; // StErr is left only through reset
            endcase
        end
    end

    always_comb begin
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        pc_next    = '0;
        branch_ack = 1'b0;
        case (state_q)
            StIdle: begin
                if (branch_req) begin
                    pc_load    = 1'b1;
                    pc_next    = branch_addr;
                    branch_ack = 1'b1;
                end
            end
            StFetch: begin
                // A branch arriving with the ack of a clean fetch is taken later from HOLD.
                branch_ack = branch_req && !pend_valid_q && !flash_ack;
                if (flash_ack && pend_valid_q) begin
                    pc_load = 1'b1;
                    pc_next = pend_addr_q;
                end
            end
            StHold: begin
                if (branch_req) begin
                    pc_load    = 1'b1;
                    pc_next    = branch_addr;
                    branch_ack = 1'b1;
                end else if (instr_ready) begin
                    pc_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign pc_gate     = pc_inc | pc_load;
    assign flash_req   = (state_q == StFetch);
    assign flash_addr  = (state_q == StFetch) ? pc_in : '0;
    assign instr_valid = (state_q == StHold);
    assign instr_data  = instr_data_q;
    assign instr_addr  = instr_addr_q;
    assign instr_boot  = instr_boot_q;
    assign fetch_error = (state_q == StErr);

endmodule
